// File: rtl/dmem_responder_pkg.sv
// Shared widths, one-hot FSM encodings and LFSR constants for the data-memory responder.
// The LFSR helpers are only referenced when DMEM_RAND_DELAY_EN is defined.
package dmem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned LFSR_W = 8;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_WAIT = 3'b010;
    localparam logic [2:0] ST_RESP = 3'b100;

    // x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7,5,4,3 of a left-shifting register
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h5A;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Byte-strobed word array: synchronous write, combinational read on a single shared index.
module dmem_sram
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [STRB_W-1:0]     strb,
    output logic [DATA_W-1:0]     rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (strb[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts byte-strobed writes and latency-delayed reads with a valid/ready response.
// Define DMEM_RAND_DELAY_EN to add LFSR-driven extra read latency and request back-pressure.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Address,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] Write_data,
    input  logic [STRB_W-1:0] Write_strb,
    input  logic              MemRead,
    output logic              Mem_Req_Ready,
    output logic [DATA_W-1:0] Read_data,
    output logic              Read_data_Valid,
    input  logic              Read_data_Ready
);

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic [DATA_W-1:0]     rdata_d;
    logic [DATA_W-1:0]     mem_rdata_c;
    logic [CNT_W-1:0]      lat_c;
    logic                  stall_c;
    logic                  accept_c;
    logic                  wr_en_c;
    logic                  rd_go_c;
    logic [ADDR_WIDTH-1:0] idx_c;
    logic                  unused_addr;

`ifdef DMEM_RAND_DELAY_EN
    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign lat_c   = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
    assign stall_c = lfsr_q[2];
`else
    assign lat_c   = CNT_W'(LATENCY);
    assign stall_c = 1'b0;
`endif

    // Word index wraps modulo depth; byte-offset and high address bits are don't-care
    assign idx_c       = Address[ADDR_WIDTH+1:2];
    assign unused_addr = ^{Address[ADDR_W-1:ADDR_WIDTH+2], Address[1:0]};

    assign Mem_Req_Ready   = (state_q == ST_IDLE) && !stall_c;
    assign Read_data_Valid = (state_q == ST_RESP);

    assign accept_c = Mem_Req_Ready && (MemRead || MemWrite);
    assign wr_en_c  = accept_c && MemWrite && !rst;
    assign rd_go_c  = accept_c && MemRead && !MemWrite;

    dmem_sram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_sram (
        .clk    (clk),
        .we     (wr_en_c),
        .addr   (idx_c),
        .wdata  (Write_data),
        .strb   (Write_strb),
        .rdata_c(mem_rdata_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            Read_data <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            Read_data <= rdata_d;
        end
    end

    // Read word is captured at accept; Read_data only changes on entry to RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        rdata_d = Read_data;
        case (state_q)
            ST_IDLE: begin
                if (rd_go_c) begin
                    if (lat_c <= CNT_W'(1)) begin
                        state_d = ST_RESP;
                        rdata_d = mem_rdata_c;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = lat_c - CNT_W'(1);
                        hold_d  = mem_rdata_c;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    rdata_d = hold_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (Read_data_Ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized check of dmem_responder against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        mem_write = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        mem_read = 1'b0;
    logic        rd_ready = 1'b0;
    logic        req_ready;
    logic [31:0] rdata;
    logic        rvalid;

    logic [31:0] addr1 = '0;
    logic        we1 = 1'b0;
    logic [31:0] wd1 = '0;
    logic [3:0]  ws1 = '0;
    logic        re1 = 1'b0;
    logic        rr1 = 1'b0;
    logic        req_ready1;
    logic [31:0] rd1;
    logic        rv1;

    int ncmp  = 0;
    int nfail = 0;

    logic [31:0] model_mem [1024];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .Address(addr), .MemWrite(mem_write),
        .Write_data(wdata), .Write_strb(wstrb), .MemRead(mem_read),
        .Mem_Req_Ready(req_ready), .Read_data(rdata),
        .Read_data_Valid(rvalid), .Read_data_Ready(rd_ready)
    );

    dmem_responder #(.ADDR_WIDTH(4), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .Address(addr1), .MemWrite(we1),
        .Write_data(wd1), .Write_strb(ws1), .MemRead(re1),
        .Mem_Req_Ready(req_ready1), .Read_data(rd1),
        .Read_data_Valid(rv1), .Read_data_Ready(rr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = model_mem[widx(a)];
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        model_mem[widx(a)] = w;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(req_ready), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wait_rdy("wr_rdy");
        addr = a; wdata = d; wstrb = s; mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
        model_write(a, d, s);
    endtask

    // Issue a read, check latency/data, hold Ready low for 'hold' cycles, then handshake.
    task automatic do_read(input string tag, input logic [31:0] a, input int hold, input bit intrude);
        logic [31:0] exp;
        int n;
        exp = model_mem[widx(a)];
        wait_rdy({tag, "_rdy"});
        addr = a; mem_read = 1'b1; rd_ready = 1'b0;
        @(negedge clk);
        mem_read = 1'b0;
        n = 1;
        while (!rvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(LAT));
        check({tag, "_data"}, rdata, exp);
        for (int h = 0; h < hold; h++) begin
            if (intrude) begin
                addr = 32'h40; wdata = 32'h0; wstrb = 4'hF; mem_write = 1'b1;
            end
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rvalid), 32'd1);
            check({tag, "_hold_data"}, rdata, exp);
            check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
        end
        mem_write = 1'b0;
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(rvalid), 32'd0);
        check({tag, "_after_rdy"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int vcount;
        logic [9:0] idx_set [16];
        logic [31:0] ra;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);

        // Ready with no pending response does nothing
        rd_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready_valid", 32'(rvalid), 32'd0);
        check("idle_ready_rdy", 32'(req_ready), 32'd1);
        rd_ready = 1'b0;

        do_write(32'h40, 32'hDEADBEEF, 4'hF);
        do_read("raw_40", 32'h40, 0, 1'b0);

        do_write(32'h80, 32'h11223344, 4'hF);
        do_write(32'h80, 32'h0000AA00, 4'b0010);
        do_read("strb_80", 32'h80, 0, 1'b0);

        // Long back-pressure, with a write presented (and ignored) while busy
        do_read("hold_80", 32'h80, 5, 1'b1);
        do_read("intrude_40", 32'h40, 0, 1'b0);

        do_write(32'h10, 32'hFFFFFFFF, 4'hF);
        wait_rdy("both_rdy");
        addr = 32'h10; wdata = 32'h5; wstrb = 4'hF; mem_write = 1'b1; mem_read = 1'b1;
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b0;
        model_write(32'h10, 32'h5, 4'hF);
        vcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (rvalid) vcount++;
        end
        check("both_no_valid", 32'(vcount), 32'd0);
        do_read("both_10", 32'h10, 0, 1'b0);

        // Reset during WAIT drops the pending read
        wait_rdy("rstwait_rdy");
        addr = 32'h40; mem_read = 1'b1;
        @(negedge clk);
        mem_read = 1'b0;
        check("rstwait_in_wait", 32'(rvalid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstwait_ready", 32'(req_ready), 32'd1);
        check("rstwait_rdata", rdata, 32'd0);
        vcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (rvalid) vcount++;
        end
        check("rstwait_no_valid", 32'(vcount), 32'd0);
        do_read("rstwait_40", 32'h40, 0, 1'b0);

        // Write concurrent with reset is suppressed
        rst = 1'b1; addr = 32'h40; wdata = 32'h0; wstrb = 4'hF; mem_write = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_write = 1'b0;
        do_read("rstwr_40", 32'h40, 0, 1'b0);

        // Upper and byte-offset address bits are ignored
        do_write(32'hABCD_1043, 32'hCAFEF00D, 4'hF);
        do_read("wrap_40", 32'h40, 0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            idx_set[i] = 10'($urandom_range(0, 1023));
            do_write({20'h0, idx_set[i], 2'b00}, $urandom(), 4'hF);
        end
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom() & 32'hFFFF_F003) | (32'(idx_set[$urandom_range(0, 15)]) << 2);
            if ($urandom_range(0, 1) == 0) begin
                do_write(ra, $urandom(), 4'($urandom_range(0, 15)));
            end else begin
                do_read("rand", ra, int'($urandom_range(0, 3)), 1'b0);
            end
        end

        // LATENCY=1 instance: back-to-back reads with a continuously asserted request
        addr1 = 32'h0; wd1 = 32'hA1A1A1A1; ws1 = 4'hF; we1 = 1'b1;
        @(negedge clk);
        addr1 = 32'h4; wd1 = 32'hB2B2B2B2;
        @(negedge clk);
        we1 = 1'b0;
        check("l1_idle_rdy", 32'(req_ready1), 32'd1);
        addr1 = 32'h0; re1 = 1'b1; rr1 = 1'b1;
        @(negedge clk);
        check("l1_first_valid", 32'(rv1), 32'd1);
        check("l1_first_data", rd1, 32'hA1A1A1A1);
        check("l1_first_busy", 32'(req_ready1), 32'd0);
        addr1 = 32'h4;
        @(negedge clk);
        check("l1_gap_valid", 32'(rv1), 32'd0);
        check("l1_gap_rdy", 32'(req_ready1), 32'd1);
        @(negedge clk);
        re1 = 1'b0;
        check("l1_second_valid", 32'(rv1), 32'd1);
        check("l1_second_data", rd1, 32'hB2B2B2B2);
        @(negedge clk);
        rr1 = 1'b0;
        check("l1_done_valid", 32'(rv1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
